// File: rtl/tile_dispatch.sv
// rtl/tile_dispatch.sv - round-robin dispatch of tile descriptors from tile_ctrl to NUM_ENG conv engines
module tile_dispatch #(
  parameter int DIM_W   = 16,
  parameter int NUM_ENG = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 src_start,
  input  logic                 src_done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*DIM_W+1:0]   in_desc,
  output logic [NUM_ENG-1:0]   eng_valid,
  input  logic [NUM_ENG-1:0]   eng_ready,
  output logic [8*DIM_W+1:0]   eng_desc,
  input  logic [NUM_ENG-1:0]   eng_done,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     tiles_issued,
  output logic [CNT_W-1:0]     tiles_completed,
  output logic                 err_spurious
);
  localparam int ENG_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t             state;
  logic [NUM_ENG-1:0] busy_mask;
  logic [NUM_ENG-1:0] free_mask;
  logic [NUM_ENG-1:0] done_ok;
  logic               out_full;
  logic               src_fin;
  logic               found;
  logic               capture;
  logic               handshake;
  logic               spurious;
  logic [ENG_W-1:0]   out_sel;
  logic [ENG_W-1:0]   rr_ptr;
  logic [ENG_W-1:0]   sel;
  logic [CNT_W-1:0]   done_cnt;
  int                 idx;

  assign free_mask = ~busy_mask;
  assign in_ready  = (state == RUN) && !out_full && (|free_mask) && !src_fin;
  assign capture   = in_valid && in_ready;
  assign eng_valid = out_full ? (NUM_ENG'(1) << out_sel) : '0;
  assign handshake = out_full && eng_ready[out_sel];
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // First free engine at or after rr_ptr, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_ENG;
      if (!found && free_mask[idx]) begin
        sel   = ENG_W'(idx);
        found = 1'b1;
      end
    end
  end

  // A completion counts only from an engine that already took its tile.
  always_comb begin
    done_ok  = '0;
    done_cnt = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      done_ok[i] = eng_done[i] && busy_mask[i] && !(out_full && (out_sel == ENG_W'(i)));
      done_cnt   = done_cnt + CNT_W'(done_ok[i]);
    end
    spurious = |(eng_done & ~done_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      src_start       <= 1'b0;
      busy_mask       <= '0;
      out_full        <= 1'b0;
      out_sel         <= '0;
      rr_ptr          <= '0;
      src_fin         <= 1'b0;
      eng_desc        <= '0;
      tiles_issued    <= '0;
      tiles_completed <= '0;
      err_spurious    <= 1'b0;
    end else begin
      src_start       <= 1'b0;
      busy_mask       <= (busy_mask & ~done_ok) | (capture ? (NUM_ENG'(1) << sel) : '0);
      tiles_completed <= tiles_completed + done_cnt;
      if (spurious) err_spurious <= 1'b1;

      if (capture) begin
        eng_desc <= in_desc;
        out_sel  <= sel;
        out_full <= 1'b1;
        rr_ptr   <= ENG_W'((int'(sel) + 1) % NUM_ENG);
      end else if (handshake) begin
        out_full     <= 1'b0;
        tiles_issued <= tiles_issued + CNT_W'(1);
      end

      case (state)
        IDLE: if (start) begin
          state           <= RUN;
          src_start       <= 1'b1;
          tiles_issued    <= '0;
          tiles_completed <= '0;
          rr_ptr          <= '0;
          src_fin         <= 1'b0;
          err_spurious    <= 1'b0;
        end
        RUN: begin
          if (src_done) src_fin <= 1'b1;
          if (src_fin && !out_full) state <= DRAIN;
        end
        DRAIN: if (busy_mask == '0) state <= FIN;
        FIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_dispatch.sv
// tb/tb_tile_dispatch.sv - directed vector table plus multi-cycle sequences for tile_dispatch
module tb_tile_dispatch;
  localparam int DIM_W   = 16;
  localparam int NUM_ENG = 4;
  localparam int CNT_W   = 16;
  localparam int DESC_W  = 8*DIM_W+2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              src_start;
  logic              src_done = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DESC_W-1:0] in_desc = '0;
  logic [3:0]        eng_valid;
  logic [3:0]        eng_ready = '0;
  logic [DESC_W-1:0] eng_desc;
  logic [3:0]        eng_done = '0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  tiles_issued;
  logic [CNT_W-1:0]  tiles_completed;
  logic              err_spurious;

  int checks = 0;
  int errors = 0;

  tile_dispatch #(.DIM_W(DIM_W), .NUM_ENG(NUM_ENG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_start(src_start), .src_done(src_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_desc(eng_desc), .eng_done(eng_done),
    .busy(busy), .done(done), .tiles_issued(tiles_issued), .tiles_completed(tiles_completed),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, src_done, in_valid;
    logic [3:0] eng_ready, eng_done;
    int         desc_id;
    logic       e_busy, e_in_ready;
    logic [3:0] e_eng_valid;
    logic       e_src_start, e_done, e_err;
    int         e_issued, e_completed, e_desc;
  } vec_t;

  vec_t tv[21];

  function automatic logic [DESC_W-1:0] mk(input int id);
    logic [15:0] f;
    f  = 16'(id) ^ 16'hA5C3;
    mk = {{8{f}}, 2'(id)};
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int n, input int lat);
    int done_at[4];
    int grants[8];
    int sent, ng, ndone, cyc;
    bit sd_sent, fin;
    for (int e = 0; e < 4; e++) done_at[e] = -1;
    sent = 0; ng = 0; ndone = 0; cyc = 0; sd_sent = 0; fin = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc < 300) begin
      for (int e = 0; e < 4; e++) begin
        eng_done[e] = (done_at[e] == cyc);
        if (done_at[e] == cyc) done_at[e] = -1;
      end
      in_valid  = (sent < n);
      in_desc   = mk(100 + sent);
      src_done  = (sent == n) && !sd_sent;
      if (src_done) sd_sent = 1;
      eng_ready = 4'hF;
      #1;
      if (eng_valid != 4'h0) begin
        for (int e = 0; e < 4; e++)
          if (eng_valid[e]) begin
            if (ng < 8) grants[ng] = e;
            done_at[e] = cyc + lat;
          end
        chk("job_desc", eng_desc, mk(100 + ng));
        ng++;
      end
      if (in_valid && in_ready) sent++;
      if (done) ndone++;
      if (!busy && ndone > 0) fin = 1;
      else begin
        tick();
        cyc++;
      end
    end
    in_valid = 0; src_done = 0; eng_ready = 0; eng_done = 0;
    chk("job_timeout", fin, 1);
    chk("job_grants", ng, n);
    for (int i = 0; i < n && i < 8; i++) chk("job_grant_order", grants[i], i % 4);
    chk("job_issued", tiles_issued, n);
    chk("job_completed", tiles_completed, n);
    chk("job_done_pulses", ndone, 1);
    chk("job_err", err_spurious, 0);
  endtask

  initial begin
    // rst st sd iv er ed did | busy ir ev ss dn err iss cmp edesc
    tv[0]  = '{1,1,0,0,4'h0,4'h0,0, 0,0,4'h0,0,0,0,0,0,-1};
    tv[1]  = '{0,0,0,0,4'h0,4'h0,0, 0,0,4'h0,0,0,0,0,0,-1};
    tv[2]  = '{0,1,0,0,4'h0,4'h0,0, 0,0,4'h0,0,0,0,0,0,-1};
    tv[3]  = '{0,0,0,1,4'h0,4'h0,0, 1,1,4'h0,1,0,0,0,0,-1};
    tv[4]  = '{0,0,0,0,4'h0,4'h0,0, 1,0,4'h1,0,0,0,0,0,0};
    tv[5]  = '{0,0,0,0,4'hF,4'h0,0, 1,0,4'h1,0,0,0,0,0,0};
    tv[6]  = '{0,0,0,1,4'h0,4'h0,1, 1,1,4'h0,0,0,0,1,0,-1};
    tv[7]  = '{0,0,0,0,4'hF,4'h0,0, 1,0,4'h2,0,0,0,1,0,1};
    tv[8]  = '{0,0,1,0,4'h0,4'h1,0, 1,1,4'h0,0,0,0,2,0,-1};
    tv[9]  = '{0,0,0,0,4'h0,4'h2,0, 1,0,4'h0,0,0,0,2,1,-1};
    tv[10] = '{0,0,0,0,4'h0,4'h0,0, 1,0,4'h0,0,0,0,2,2,-1};
    tv[11] = '{0,0,0,0,4'h0,4'h0,0, 1,0,4'h0,0,1,0,2,2,-1};
    tv[12] = '{0,0,0,0,4'h0,4'h0,0, 0,0,4'h0,0,0,0,2,2,-1};
    tv[13] = '{0,0,0,0,4'h0,4'h8,0, 0,0,4'h0,0,0,0,2,2,-1};
    tv[14] = '{0,1,0,0,4'h0,4'h0,0, 0,0,4'h0,0,0,1,2,2,-1};
    tv[15] = '{0,0,0,0,4'h0,4'h0,0, 1,1,4'h0,1,0,0,0,0,-1};
    tv[16] = '{0,0,1,0,4'h0,4'h0,0, 1,1,4'h0,0,0,0,0,0,-1};
    tv[17] = '{0,0,0,0,4'h0,4'h0,0, 1,0,4'h0,0,0,0,0,0,-1};
    tv[18] = '{0,0,0,0,4'h0,4'h0,0, 1,0,4'h0,0,0,0,0,0,-1};
    tv[19] = '{0,0,0,0,4'h0,4'h0,0, 1,0,4'h0,0,1,0,0,0,-1};
    tv[20] = '{0,0,0,0,4'h0,4'h0,0, 0,0,4'h0,0,0,0,0,0,-1};

    @(posedge clk);
    for (int i = 0; i < 21; i++) begin
      tick();
      rst = tv[i].rst; start = tv[i].start; src_done = tv[i].src_done;
      in_valid = tv[i].in_valid; in_desc = mk(tv[i].desc_id);
      eng_ready = tv[i].eng_ready; eng_done = tv[i].eng_done;
      #1;
      chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("v%0d_in_ready", i), in_ready, tv[i].e_in_ready);
      chk($sformatf("v%0d_eng_valid", i), eng_valid, tv[i].e_eng_valid);
      chk($sformatf("v%0d_src_start", i), src_start, tv[i].e_src_start);
      chk($sformatf("v%0d_done", i), done, tv[i].e_done);
      chk($sformatf("v%0d_err", i), err_spurious, tv[i].e_err);
      chk($sformatf("v%0d_issued", i), tiles_issued, tv[i].e_issued);
      chk($sformatf("v%0d_completed", i), tiles_completed, tv[i].e_completed);
      if (tv[i].e_desc >= 0) chk($sformatf("v%0d_desc", i), eng_desc, mk(tv[i].e_desc));
    end
    rst = 0; start = 0; src_done = 0; in_valid = 0; eng_ready = 0; eng_done = 0;

    // Stalled offer: engine 0 withholds ready for 5 cycles.
    tick(); start = 1;
    tick(); start = 0; in_valid = 1; in_desc = mk(10);
    #1 chk("stall_in_ready0", in_ready, 1);
    tick(); in_desc = mk(11); eng_ready = 4'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_eng_valid", eng_valid, 4'h1);
      chk("stall_desc", eng_desc, mk(10));
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    eng_ready = 4'h1;
    tick(); eng_ready = 4'h0;
    #1 chk("stall_issued", tiles_issued, 1);
    tick(); eng_ready = 4'hF;
    tick(); eng_ready = 4'h0; in_desc = mk(12);
    tick(); eng_ready = 4'hF;
    tick(); eng_ready = 4'h0; in_desc = mk(13);
    tick(); eng_ready = 4'hF;
    tick(); eng_ready = 4'h0; in_desc = mk(14);

    // All engines busy: descriptor held off until engine 2 completes.
    #1;
    chk("full_issued", tiles_issued, 4);
    chk("full_in_ready", in_ready, 0);
    tick();
    chk("full_in_ready2", in_ready, 0);
    eng_done = 4'h4;
    #1 chk("full_in_ready_pre", in_ready, 0);
    tick(); eng_done = 4'h0;
    #1;
    chk("freed_in_ready", in_ready, 1);
    chk("freed_completed", tiles_completed, 1);
    tick(); in_valid = 0;
    #1;
    chk("freed_grant", eng_valid, 4'h4);
    chk("freed_desc", eng_desc, mk(14));
    // Completion from an engine still being offered is spurious.
    eng_done = 4'h4;
    tick(); eng_done = 4'h0;
    #1;
    chk("offer_done_err", err_spurious, 1);
    chk("offer_done_completed", tiles_completed, 1);
    chk("offer_done_valid", eng_valid, 4'h4);
    src_done = 1;
    tick(); src_done = 0;
    tick(); tick();
    #1;
    chk("srcfin_hold_valid", eng_valid, 4'h4);
    chk("srcfin_in_ready", in_ready, 0);
    eng_ready = 4'h4;
    tick(); eng_ready = 4'h0;
    #1 chk("drain_issued", tiles_issued, 5);
    tick(); tick(); tick();
    #1;
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);

    // Reset mid-drain aborts without a done pulse.
    rst = 1;
    tick(); rst = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_issued", tiles_issued, 0);
    chk("abort_completed", tiles_completed, 0);
    chk("abort_err", err_spurious, 0);
    chk("abort_eng_valid", eng_valid, 4'h0);
    tick();
    chk("abort_done2", done, 0);

    run_job(6, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
